// File: rtl/ycr1_icache_mem_resp.sv
// Icache-side read responder: accepts read bursts from the router and returns
// one SRAM word per beat, marking the final beat RDY_LOK or a bad request RDY_ER.
module ycr1_icache_mem_resp #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter int                BSIZE     = 3,
    parameter int                MEM_AW    = 10,
    parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              cmd_i,
    input  logic [1:0]        width_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [BSIZE-1:0]  bl_i,
    output logic              req_ack_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic [1:0]        resp_o,
    output logic              mem_cs_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [1:0]        state_o
);

    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_OK     = 2'b01;
    localparam logic [1:0] RESP_ER     = 2'b10;
    localparam logic [1:0] RESP_LOK    = 2'b11;

    localparam logic [BSIZE-1:0]  BEAT_ONE = BSIZE'(1);
    localparam logic [MEM_AW-1:0] WORD_ONE = MEM_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_ERR   = 2'd2
    } state_e;

    state_e            state_q;
    logic [BSIZE-1:0]  remaining_q;
    logic [MEM_AW-1:0] next_addr_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [MEM_AW-1:0] mem_addr_d;

    logic [AWIDTH:0]   offset;
    logic              in_window;
    logic              misaligned;
    logic              req_err;
    logic [MEM_AW-1:0] start_word;

    // Borrow out of the subtraction means the address lies below the base;
    // any set bit above the SRAM byte range means it lies past the end.
    assign offset     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign in_window  = !offset[AWIDTH] && ((offset[AWIDTH-1:0] >> (MEM_AW + 2)) == '0);
    assign start_word = offset[MEM_AW+1:2];

    assign misaligned = ((width_i == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                        ((width_i == 2'b01) && addr_i[0]);

    assign req_err = cmd_i || (bl_i == '0) || !in_window || misaligned ||
                     (width_i == 2'b11);

    assign state_o = state_q;

    // Handshake: a request is taken in any cycle where req_i and req_ack_o are
    // both high; req_ack_o is only raised in IDLE outside reset, and the fields
    // are sampled in that cycle alone. Responses flow without back-pressure.
    always_comb begin
        req_ack_o  = 1'b0;
        mem_cs_o   = 1'b0;
        mem_addr_d = mem_addr_q;
        resp_o     = RESP_NOTRDY;
        rdata_o    = '0;
        if (rst_n) begin
            unique case (state_q)
                S_IDLE: begin
                    req_ack_o = req_i;
                    if (req_i && !req_err) begin
                        mem_cs_o   = 1'b1;
                        mem_addr_d = start_word;
                    end
                end
                S_BURST: begin
                    rdata_o = mem_rdata_i;
                    resp_o  = (remaining_q == '0) ? RESP_LOK : RESP_OK;
                    if (remaining_q != '0) begin
                        mem_cs_o   = 1'b1;
                        mem_addr_d = next_addr_q;
                    end
                end
                S_ERR: begin
                    resp_o = RESP_ER;
                end
                default: begin
                    resp_o = RESP_NOTRDY;
                end
            endcase
        end
    end

    assign mem_addr_o = mem_addr_d;

    // remaining_q counts SRAM reads still to issue; the beat that sees zero is last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            next_addr_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            unique case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        if (req_err) begin
                            state_q <= S_ERR;
                        end else begin
                            state_q     <= S_BURST;
                            remaining_q <= bl_i - BEAT_ONE;
                            next_addr_q <= start_word + WORD_ONE;
                        end
                    end
                end
                S_BURST: begin
                    if (remaining_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        remaining_q <= remaining_q - BEAT_ONE;
                        next_addr_q <= next_addr_q + WORD_ONE;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ycr1_icache_mem_resp.sv
// Bench for ycr1_icache_mem_resp: directed vector table, hand-built corner
// sequences and random requests checked against a rule-level request model.
module tb_ycr1_icache_mem_resp;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [2:0]  bl;
    logic        req_ack;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        mem_cs;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    logic [31:0] sram [0:1023];
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    ycr1_icache_mem_resp #(
        .AWIDTH    (32),
        .DWIDTH    (32),
        .BSIZE     (3),
        .MEM_AW    (10),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .cmd_i       (cmd),
        .width_i     (width),
        .addr_i      (addr),
        .bl_i        (bl),
        .req_ack_o   (req_ack),
        .rdata_o     (rdata),
        .resp_o      (resp),
        .mem_cs_o    (mem_cs),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .state_o     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_cs) mem_rdata <= sram[mem_addr];
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_resp"},  {30'd0, resp}, 32'd0);
        check({name, "_rdata"}, rdata, 32'd0);
        check({name, "_cs"},    {31'd0, mem_cs}, 32'd0);
        check({name, "_ack"},   {31'd0, req_ack}, 32'd0);
    endtask

    // Request-level reference: error rules and start word from plain arithmetic.
    function automatic bit model_err(input logic c, input logic [1:0] w,
                                     input logic [31:0] a, input logic [2:0] b);
        if (c) return 1'b1;
        if (b == 0) return 1'b1;
        if (w == 2'd3) return 1'b1;
        if (a >= 32'd4096) return 1'b1;
        if (w == 2'd2 && (a % 4) != 0) return 1'b1;
        if (w == 2'd1 && (a % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_noise();
        req   = 1'($urandom_range(0, 1));
        cmd   = 1'($urandom_range(0, 1));
        width = 2'($urandom_range(0, 3));
        addr  = $urandom;
        bl    = 3'($urandom_range(0, 7));
    endtask

    task automatic run_txn(input logic c, input logic [1:0] w, input logic [31:0] a,
                           input logic [2:0] b, input bit exp_err, input int w0);
        @(negedge clk);
        req = 1'b1; cmd = c; width = w; addr = a; bl = b;
        #2;
        check("accept_ack",  {31'd0, req_ack}, 32'd1);
        check("accept_resp", {30'd0, resp}, 32'd0);
        check("accept_cs",   {31'd0, mem_cs}, {31'd0, !exp_err});
        if (!exp_err) begin
            check("accept_addr", {22'd0, mem_addr}, 32'(w0));
            for (int k = 0; k < int'(b); k++) exp_q.push_back(sram[(w0 + k) % 1024]);
        end
        if (exp_err) begin
            @(negedge clk); drive_noise(); #2;
            check("err_resp",  {30'd0, resp}, 32'd2);
            check("err_rdata", rdata, 32'd0);
            check("err_cs",    {31'd0, mem_cs}, 32'd0);
            check("err_ack",   {31'd0, req_ack}, 32'd0);
        end else begin
            for (int k = 1; k <= int'(b); k++) begin
                @(negedge clk); drive_noise(); #2;
                check("beat_resp",  {30'd0, resp}, (k == int'(b)) ? 32'd3 : 32'd1);
                check("beat_rdata", rdata, exp_q.pop_front());
                check("beat_ack",   {31'd0, req_ack}, 32'd0);
                check("beat_cs",    {31'd0, mem_cs}, (k < int'(b)) ? 32'd1 : 32'd0);
                if (k < int'(b)) check("beat_addr", {22'd0, mem_addr}, 32'((w0 + k) % 1024));
            end
        end
        @(negedge clk); req = 1'b0; #2;
        check_idle("post");
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        cmd;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [2:0]  bl;
        bit          exp_err;
        int          exp_w0;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int b2b_resp [6];
        int b2b_ack  [6];
        int ack_cycles [$];

        vecs[0]  = '{1'b0, 2'd2, 32'h0000_0010, 3'd1, 1'b0, 4};
        vecs[1]  = '{1'b0, 2'd2, 32'h0000_0020, 3'd4, 1'b0, 8};
        vecs[2]  = '{1'b0, 2'd2, 32'h0000_0FF8, 3'd4, 1'b0, 1022};
        vecs[3]  = '{1'b1, 2'd2, 32'h0000_0020, 3'd2, 1'b1, 0};
        vecs[4]  = '{1'b0, 2'd2, 32'h0000_0020, 3'd0, 1'b1, 0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0000_0002, 3'd1, 1'b1, 0};
        vecs[6]  = '{1'b0, 2'd2, 32'h0000_1000, 3'd1, 1'b1, 0};
        vecs[7]  = '{1'b0, 2'd3, 32'h0000_0040, 3'd1, 1'b1, 0};
        vecs[8]  = '{1'b0, 2'd1, 32'h0000_0041, 3'd1, 1'b1, 0};
        vecs[9]  = '{1'b0, 2'd1, 32'h0000_0042, 3'd2, 1'b0, 16};
        vecs[10] = '{1'b0, 2'd0, 32'h0000_0043, 3'd3, 1'b0, 16};
        vecs[11] = '{1'b0, 2'd2, 32'h0000_0FFC, 3'd7, 1'b0, 1023};
        vecs[12] = '{1'b0, 2'd2, 32'hFFFF_FFFC, 3'd1, 1'b1, 0};

        for (int i = 0; i < 1024; i++) sram[i] = $urandom;
        sram[8]  = 32'hAAAA_0001;
        sram[9]  = 32'hBBBB_0002;
        sram[10] = 32'hCCCC_0003;
        sram[11] = 32'hDDDD_0004;

        // Reset held with a pending request: nothing may respond.
        rst_n = 1'b0; req = 1'b1; cmd = 1'b0; width = 2'd2; addr = 32'h10; bl = 3'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #2;
            check("rst_ack",  {31'd0, req_ack}, 32'd0);
            check("rst_resp", {30'd0, resp}, 32'd0);
            check("rst_cs",   {31'd0, mem_cs}, 32'd0);
        end
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1; req = 1'b0; #2;
        check_idle("rel");

        for (int i = 0; i < 13; i++)
            run_txn(vecs[i].cmd, vecs[i].width, vecs[i].addr, vecs[i].bl,
                    vecs[i].exp_err, vecs[i].exp_w0);

        // Back-to-back bursts of two with req held high.
        b2b_resp = '{0, 1, 3, 0, 1, 3};
        b2b_ack  = '{1, 0, 0, 1, 0, 0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = 1'b1; cmd = 1'b0; width = 2'd2; addr = 32'h0000_0040; bl = 3'd2;
            #2;
            check("b2b_resp", {30'd0, resp}, 32'(b2b_resp[c]));
            check("b2b_ack",  {31'd0, req_ack}, 32'(b2b_ack[c]));
            if (req_ack) ack_cycles.push_back(c);
            if (b2b_resp[c] != 0) check("b2b_rdata", rdata, sram[16 + ((c % 3) - 1)]);
        end
        @(negedge clk); req = 1'b0; #2;
        // The cycle just seen completes the second burst handshake's LOK window.
        check_idle("b2b_end");
        check("b2b_ack_count", 32'(ack_cycles.size()), 32'd2);
        if (ack_cycles.size() == 2)
            check("b2b_ack_gap", 32'(ack_cycles[1] - ack_cycles[0]), 32'd3);

        // Reset arriving on the third beat of a seven-beat burst.
        @(negedge clk);
        req = 1'b1; cmd = 1'b0; width = 2'd2; addr = 32'h0000_0100; bl = 3'd7;
        #2;
        check("mid_accept_ack", {31'd0, req_ack}, 32'd1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); req = 1'b0; #2;
            check("mid_beat_resp",  {30'd0, resp}, 32'd1);
            check("mid_beat_rdata", rdata, sram[64 + k - 1]);
        end
        @(negedge clk); rst_n = 1'b0; #2;
        check("mid_rst_no_lok", {31'd0, resp == 2'b11}, 32'd0);
        @(negedge clk); rst_n = 1'b1; #2;
        check_idle("mid_after");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            check("mid_quiet_resp", {30'd0, resp}, 32'd0);
            check("mid_quiet_cs",   {31'd0, mem_cs}, 32'd0);
        end
        run_txn(1'b0, 2'd2, 32'h0000_0200, 3'd3, 1'b0, 128);

        // Random requests against the rule-level model.
        for (int i = 0; i < 60; i++) begin
            logic        c;
            logic [1:0]  w;
            logic [31:0] a;
            logic [2:0]  b;
            bit          e;
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 1023)) * 4;
                1:       a = 32'($urandom_range(0, 32'h1FFF));
                2:       a = 32'($urandom_range(32'hFE0, 32'hFFF));
                default: a = $urandom;
            endcase
            c = ($urandom_range(0, 7) == 0);
            w = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            b = 3'($urandom_range(0, 7));
            e = model_err(c, w, a, b);
            run_txn(c, w, a, b, e, int'((a / 4) % 1024));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
